clkdiv_tick_gen: RTL and testbench



---
 rtl/clkdiv_tick_gen_pkg.sv | 21 ++
 rtl/sq_divider.sv | 45 ++++
 rtl/clkdiv_tick_gen.sv | 103 ++++++++++
 tb/tb_clkdiv_tick_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_tick_gen_pkg.sv
// Shared definitions for the calendar clock path: handover FSM states,
// the default board clock rate and divider counter sizing.
package clkdiv_tick_gen_pkg;

    typedef enum logic [1:0] {
        SEL_SLOW = 2'd0,
        DRAIN    = 2'd1,
        HOLD     = 2'd2,
        SEL_FAST = 2'd3
    } clk_sel_state_e;

    localparam int CLK_HZ_DEFAULT = 100_000_000;

    // Counter width able to hold 0..max(a,b)-1; never narrower than one bit.
    function automatic int half_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sq_divider.sv
// Free-running half-period divider: ~50% square wave plus a one-clock strobe
// registered in the same cycle the wave rises.
module sq_divider
    import clkdiv_tick_gen_pkg::*;
#(
    parameter int HALF = 2,
    parameter int CW   = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic sq_o,
    output logic tick_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (cnt_q == CW'(HALF - 1)) begin
            cnt_d  = '0;
            sq_d   = ~sq_q;
            tick_d = ~sq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sq_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
        end
    end

    assign sq_o   = sq_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clkdiv_tick_gen.sv
// Derives the fast scan and slow count clocks from the board clock and hands
// clk_trl between them glitch-free according to the synchronised sd switch.
module clkdiv_tick_gen
    import clkdiv_tick_gen_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int FAST_HZ = 190,
    parameter int SLOW_HZ = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sd,
    output logic outclk190,
    output logic outclk12,
    output logic tick190,
    output logic tick12,
    output logic clk_trl,
    output logic sel_fast,
    output logic busy
);

    localparam int HALF_F = CLK_HZ / (2 * FAST_HZ);
    localparam int HALF_S = CLK_HZ / (2 * SLOW_HZ);
    localparam int CW     = half_w(HALF_F, HALF_S);

    if (HALF_F < 2 || HALF_S < 2) begin : g_half_check
        $error("clkdiv_tick_gen: both half-period constants must be at least 2");
    end

    logic fast_sq, slow_sq;

    sq_divider #(.HALF(HALF_F), .CW(CW)) u_div_fast (
        .clk    (clk),
        .rst_n  (rst_n),
        .sq_o   (fast_sq),
        .tick_o (tick190)
    );

    sq_divider #(.HALF(HALF_S), .CW(CW)) u_div_slow (
        .clk    (clk),
        .rst_n  (rst_n),
        .sq_o   (slow_sq),
        .tick_o (tick12)
    );

    logic           sd_meta_q, sd_s_q;
    clk_sel_state_e state_q, state_d;
    logic           sel_q, sel_d;
    logic           trl_q, trl_d;
    logic           cur_lvl, tgt_lvl;

    assign cur_lvl = sel_q ? fast_sq : slow_sq;
    assign tgt_lvl = sel_q ? slow_sq : fast_sq;

    // clk_trl only leaves a source while it is low and only joins the new one
    // while it is low, so every pulse it emits is a whole source high phase.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        trl_d   = 1'b0;
        case (state_q)
            SEL_SLOW, SEL_FAST: begin
                trl_d = cur_lvl;
                if (sd_s_q != sel_q) state_d = DRAIN;
            end
            DRAIN: begin
                trl_d = cur_lvl;
                if (sd_s_q == sel_q)  state_d = sel_q ? SEL_FAST : SEL_SLOW;
                else if (!cur_lvl)    state_d = HOLD;
            end
            HOLD: begin
                if (!tgt_lvl) begin
                    sel_d   = ~sel_q;
                    state_d = sel_q ? SEL_SLOW : SEL_FAST;
                end
            end
            default: state_d = SEL_SLOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_meta_q <= 1'b0;
            sd_s_q    <= 1'b0;
            state_q   <= SEL_SLOW;
            sel_q     <= 1'b0;
            trl_q     <= 1'b0;
        end else begin
            sd_meta_q <= sd;
            sd_s_q    <= sd_meta_q;
            state_q   <= state_d;
            sel_q     <= sel_d;
            trl_q     <= trl_d;
        end
    end

    assign outclk190 = fast_sq;
    assign outclk12  = slow_sq;
    assign clk_trl   = trl_q;
    assign sel_fast  = sel_q;
    assign busy      = (state_q == DRAIN) || (state_q == HOLD);

endmodule

// File: tb/tb_clkdiv_tick_gen.sv
// Bench for clkdiv_tick_gen: arithmetic divider model plus handover model,
// directed scenarios pinned with literals, then randomized sd toggling.
module tb_clkdiv_tick_gen;

    localparam int HF       = 5;
    localparam int HS       = 79;
    localparam int BUSY_MAX = 2 * HS + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sd    = 1'b0;
    logic outclk190, outclk12, tick190, tick12, clk_trl, sel_fast, busy;

    always #5 clk = ~clk;

    clkdiv_tick_gen #(.CLK_HZ(1900), .FAST_HZ(190), .SLOW_HZ(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sd        (sd),
        .outclk190 (outclk190),
        .outclk12  (outclk12),
        .tick190   (tick190),
        .tick12    (tick12),
        .clk_trl   (clk_trl),
        .sel_fast  (sel_fast),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_ok(input string name, input bit ok, input int act);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: observed %0d violates the bound (t=%0t)", name, act, $time);
    endtask

    // Level of a divider output after n clock edges since reset release.
    function automatic bit lev(input int half, input int n);
        return ((n / half) % 2) == 1;
    endfunction

    function automatic bit rose(input int half, input int n);
        return (n > 0) && (n % half == 0) && lev(half, n);
    endfunction

    // Model state: edge count, synchroniser pipeline, handover phase
    // (0 = settled, 1 = waiting for current source low, 2 = waiting for target low).
    int m_n, m_phase;
    bit m_sel, m_sd1, m_sds, m_trl;
    int hi_len, busy_len;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_phase = 0; m_sel = 0; m_sd1 = 0; m_sds = 0; m_trl = 0;
            hi_len = 0; busy_len = 0;
            check("rst_outclk190", outclk190, 0);
            check("rst_outclk12",  outclk12,  0);
            check("rst_tick190",   tick190,   0);
            check("rst_tick12",    tick12,    0);
            check("rst_clk_trl",   clk_trl,   0);
            check("rst_sel_fast",  sel_fast,  0);
            check("rst_busy",      busy,      0);
        end else begin
            bit f, s, cur, tgt;
            f   = lev(HF, m_n);
            s   = lev(HS, m_n);
            cur = m_sel ? f : s;
            tgt = m_sel ? s : f;
            if (m_phase == 2) begin
                m_trl = 0;
                if (!tgt) begin m_sel = !m_sel; m_phase = 0; end
            end else begin
                m_trl = cur;
                if (m_sds == m_sel)  m_phase = 0;
                else if (m_phase == 0) m_phase = 1;
                else if (!cur)       m_phase = 2;
            end
            m_sds = m_sd1;
            m_sd1 = sd;
            m_n++;
            check("outclk190", outclk190, lev(HF, m_n));
            check("outclk12",  outclk12,  lev(HS, m_n));
            check("tick190",   tick190,   rose(HF, m_n));
            check("tick12",    tick12,    rose(HS, m_n));
            check("clk_trl",   clk_trl,   m_trl);
            check("sel_fast",  sel_fast,  m_sel);
            check("busy",      busy,      (m_phase != 0));
            if (clk_trl) hi_len++;
            else if (hi_len > 0) begin
                check_ok("clk_trl_high_phase", (hi_len == HF) || (hi_len == HS), hi_len);
                hi_len = 0;
            end
            if (busy) busy_len++;
            else if (busy_len > 0) begin
                check_ok("busy_length", busy_len <= BUSY_MAX, busy_len);
                busy_len = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic scen_release();
        int n_t190;
        n_t190 = 0;
        rst_n  = 1'b1;
        while (m_n < 170) begin
            step();
            if (tick190) n_t190++;
            case (m_n)
                4:   check("s1_o190_before_first_rise", outclk190, 0);
                5:   begin check("s1_o190_first_rise", outclk190, 1); check("s1_tick190_first", tick190, 1); end
                6:   check("s1_tick190_one_wide", tick190, 0);
                10:  check("s1_o190_first_fall", outclk190, 0);
                15:  check("s1_tick190_second", tick190, 1);
                78:  check("s1_o12_before_rise", outclk12, 0);
                79:  begin check("s1_o12_first_rise", outclk12, 1); check("s1_tick12", tick12, 1);
                           check("s1_trl_lags", clk_trl, 0); end
                80:  check("s1_trl_follows_o12", clk_trl, 1);
                158: check("s1_o12_fall", outclk12, 0);
                default: ;
            endcase
        end
        check("s1_tick190_count", n_t190, 17);
        check("s1_sel_fast", sel_fast, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        sd    = 1'b0;
        repeat (3) step();
        scen_release();

        // slow -> fast while outclk12 high
        while (m_n < 240) step();
        sd = 1'b1;
        while (m_n < 330) begin
            step();
            case (m_n)
                242: check("s2_busy_not_yet", busy, 0);
                243: check("s2_busy_rises", busy, 1);
                316: check("s2_trl_high_until_fall", clk_trl, 1);
                317: check("s2_trl_low_in_hold", clk_trl, 0);
                320: check("s2_sel_before_commit", sel_fast, 0);
                321: begin check("s2_sel_commit", sel_fast, 1); check("s2_busy_done", busy, 0); end
                default: ;
            endcase
        end

        // fast -> slow with both sources low
        while (m_n < 347) step();
        sd = 1'b0;
        while (m_n < 355) begin
            step();
            case (m_n)
                349: check("s3_busy_not_yet", busy, 0);
                350: check("s3_drain", busy, 1);
                351: begin check("s3_hold", busy, 1); check("s3_sel_still_fast", sel_fast, 1); end
                352: begin check("s3_done", busy, 0); check("s3_sel_slow", sel_fast, 0); end
                default: ;
            endcase
        end

        // short sd pulse during long outclk12 high phase
        while (m_n < 400) step();
        sd = 1'b1;
        while (m_n < 470) begin
            step();
            if (m_n == 403) sd = 1'b0;
            check("s4_trl_tracks_o12", clk_trl, lev(HS, m_n - 1));
            case (m_n)
                403: check("s4_busy_drain", busy, 1);
                405: check("s4_busy_still", busy, 1);
                406: check("s4_reverted", busy, 0);
                default: ;
            endcase
        end
        check("s4_sel_slow", sel_fast, 0);

        // reset in HOLD
        while (m_n < 481) step();
        sd = 1'b1;
        while (m_n < 486) step();
        check("s5_in_hold", busy, 1);
        rst_n = 1'b0;
        #1;
        check("s5_async_o190",  outclk190, 0);
        check("s5_async_o12",   outclk12,  0);
        check("s5_async_trl",   clk_trl,   0);
        check("s5_async_busy",  busy,      0);
        check("s5_async_sel",   sel_fast,  0);
        sd = 1'b0;
        repeat (3) step();
        scen_release();

        // random sd toggling
        begin
            int n0;
            n0 = m_n;
            while (m_n - n0 < 20000) begin
                repeat ($urandom_range(37, 113)) step();
                #($urandom_range(0, 3));
                sd = ~sd;
            end
        end
        repeat (200) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
